// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake and result bus between the UART receive path and the BCD converter.
// start is sampled only while the converter is idle; done is a single-cycle pulse marking a fresh BCD.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      data_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   BCD;

  modport master (output start, output data_in, input busy, input done, input BCD);
  modport slave  (input start, input data_in, output busy, output done, output BCD);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift-and-add-3 step per clock,
// result held in a separate register so the display never sees intermediate shift values.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic              clock,
  input  logic              reset,
  bin2bcd_seq_if.slave      bus,
  output logic              dbg_state
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint MAX_IN = (longint'(1) << WIDTH) - 1;

  generate
    if (pow10(DIGITS) <= MAX_IN) begin : g_digits_check
      $error("bin2bcd_seq: DIGITS too small to represent 2^WIDTH-1");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            done_q, done_d;
  logic [SW-1:0]   adj;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    adj     = shift_q;
    // Nibbles adjust independently from pre-shift values; a digit <= 12 never carries out.
    for (int i = 0; i < DIGITS; i++) begin
      if (shift_q[WIDTH+4*i +: 4] >= 4'd5)
        adj[WIDTH+4*i +: 4] = shift_q[WIDTH+4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d = {{BW{1'b0}}, bus.data_in};
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = adj << 1;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          bcd_d   = shift_d[SW-1 -: BW];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state_q == SHIFT);
    bus.done  = done_q;
    bus.BCD   = bcd_q;
    dbg_state = state_q;
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed handshake scenarios plus a full input sweep and random
// conversions, all checked against a decimal-division reference model.
module tb_bin2bcd_seq;
  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic dbg_state;

  int tests_run = 0;
  int fails     = 0;
  logic [BW-1:0] exp_q[$];

  always #5 clock = ~clock;

  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Reference: decimal digits by repeated division.
  function automatic logic [BW-1:0] ref_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Driver: one-cycle start pulse, then observe until two cycles past the first done.
  task automatic run_conv(input logic [WIDTH-1:0] v, output logic [BW-1:0] got,
                          output int lat, output int busy_cnt, output int done_cnt);
    @(negedge clock);
    bus.start   = 1'b1;
    bus.data_in = v;
    lat = -1; busy_cnt = 0; done_cnt = 0; got = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = i - 1;
          got = bus.BCD;
        end
      end
      if (lat >= 0 && i >= lat + 3) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b1;
    bus.data_in = 8'd255;
    repeat (2) @(negedge clock);
    tests_run++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    tests_run++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    tests_run++;
    if (bus.BCD !== 12'h000) begin fails++; $display("FAIL reset_bcd got=%h exp=000", bus.BCD); end
    tests_run++;
    if (dbg_state !== 1'b0) begin fails++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_first();
    logic [BW-1:0] got; int lat, bc, dc;
    run_conv(8'd255, got, lat, bc, dc);
    tests_run++;
    if (got !== 12'h255) begin fails++; $display("FAIL first_bcd got=%h exp=255", got); end
    tests_run++;
    if (lat != WIDTH) begin fails++; $display("FAIL first_latency got=%0d exp=%0d", lat, WIDTH); end
    tests_run++;
    if (bc != WIDTH) begin fails++; $display("FAIL first_busy_cycles got=%0d exp=%0d", bc, WIDTH); end
    tests_run++;
    if (dc != 1) begin fails++; $display("FAIL first_done_pulses got=%0d exp=1", dc); end
  endtask

  task automatic test_sequence();
    int vals[5] = '{0, 9, 10, 99, 100};
    logic [BW-1:0] got, exp; int lat, bc, dc;
    foreach (vals[i]) exp_q.push_back(ref_bcd(vals[i]));
    foreach (vals[i]) begin
      run_conv(WIDTH'(vals[i]), got, lat, bc, dc);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin fails++; $display("FAIL seq_bcd in=%0d got=%h exp=%h", vals[i], got, exp); end
      tests_run++;
      if (dc != 1) begin fails++; $display("FAIL seq_done_pulses in=%0d got=%0d exp=1", vals[i], dc); end
    end
  endtask

  task automatic test_sweep();
    logic [BW-1:0] got, exp; int lat, bc, dc;
    int unsigned v;
    for (int n = 0; n < (1 << WIDTH) + 30; n++) begin
      v = (n < (1 << WIDTH)) ? n : $urandom_range((1 << WIDTH) - 1, 0);
      exp_q.push_back(ref_bcd(v));
      run_conv(WIDTH'(v), got, lat, bc, dc);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp || lat != WIDTH || bc != WIDTH || dc != 1) begin
        fails++;
        $display("FAIL sweep in=%0d bcd=%h exp=%h lat=%0d busy=%0d done=%0d", v, got, exp, lat, bc, dc);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [BW-1:0] got; int bc, dc;
    got = '0; bc = 0; dc = 0;
    @(negedge clock);
    bus.start = 1'b1; bus.data_in = 8'd200;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clock);
      bus.start   = (i == 3);
      bus.data_in = (i == 3) ? 8'd17 : 8'd200;
      if (bus.busy) bc++;
      if (bus.done) begin dc++; got = bus.BCD; end
    end
    tests_run++;
    if (got !== 12'h200) begin fails++; $display("FAIL ignore_bcd got=%h exp=200", got); end
    tests_run++;
    if (dc != 1) begin fails++; $display("FAIL ignore_done_pulses got=%0d exp=1", dc); end
    tests_run++;
    if (bc != WIDTH) begin fails++; $display("FAIL ignore_busy_cycles got=%0d exp=%0d", bc, WIDTH); end
  endtask

  task automatic test_data_change();
    logic [BW-1:0] got; int dc;
    got = '0; dc = 0;
    @(negedge clock);
    bus.start = 1'b1; bus.data_in = 8'd123;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      bus.start = 1'b0;
      bus.data_in = 8'd45;
      if (bus.done) begin dc++; got = bus.BCD; end
    end
    tests_run++;
    if (got !== 12'h123 || dc != 1) begin
      fails++; $display("FAIL data_change got=%h exp=123 done=%0d", got, dc);
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] got2; int dc, t0, lat2;
    dc = 0; t0 = -1; lat2 = -1; got2 = '0;
    @(negedge clock);
    bus.start = 1'b1; bus.data_in = 8'd250;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (bus.done) begin
        dc++;
        if (dc == 1) begin
          tests_run++;
          if (bus.BCD !== 12'h250) begin fails++; $display("FAIL b2b_first_bcd got=%h exp=250", bus.BCD); end
          bus.start = 1'b1; bus.data_in = 8'd7;
          t0 = i;
        end else if (dc == 2) begin
          lat2 = i - t0 - 1;
          got2 = bus.BCD;
        end
      end
    end
    tests_run++;
    if (got2 !== 12'h007) begin fails++; $display("FAIL b2b_second_bcd got=%h exp=007", got2); end
    tests_run++;
    if (lat2 != WIDTH) begin fails++; $display("FAIL b2b_latency got=%0d exp=%0d", lat2, WIDTH); end
    tests_run++;
    if (dc != 2) begin fails++; $display("FAIL b2b_done_pulses got=%0d exp=2", dc); end
  endtask

  task automatic test_reset_abort();
    logic [BW-1:0] got; int lat, bc, dc;
    run_conv(8'd42, got, lat, bc, dc);
    tests_run++;
    if (got !== 12'h042) begin fails++; $display("FAIL abort_prior got=%h exp=042", got); end
    @(negedge clock);
    bus.start = 1'b1; bus.data_in = 8'd199;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.BCD !== 12'h000) begin
      fails++; $display("FAIL abort_reset busy=%b done=%b bcd=%h exp 0/0/000", bus.busy, bus.done, bus.BCD);
    end
    reset = 1'b1;
    dc = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (bus.done) dc++;
    end
    tests_run++;
    if (dc != 0 || bus.BCD !== 12'h000) begin
      fails++; $display("FAIL abort_no_done done=%0d bcd=%h exp 0/000", dc, bus.BCD);
    end
    run_conv(8'd199, got, lat, bc, dc);
    tests_run++;
    if (got !== 12'h199 || lat != WIDTH) begin
      fails++; $display("FAIL abort_recover got=%h lat=%0d exp 199/%0d", got, lat, WIDTH);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.data_in = '0;
    test_reset();
    test_first();
    test_sequence();
    test_sweep();
    test_ignore_start();
    test_data_change();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout after %0d tests", tests_run);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It sits between the UART receive path and the seven-segment display driver. It accepts a received byte under a start/done handshake and holds the packed BCD result stable for the display multiplexer. It is a multi-cycle alternative to the combinational converter and trades latency for area.

Parameters:
WIDTH, 8, binary input width in bits
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH - 1 (elaboration-time check, error if violated)

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock
start  input  1  request to convert data_in; sampled only in IDLE
data_in  input  WIDTH  unsigned binary value; captured on the edge where start is accepted
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; BCD is valid and newly updated
BCD  output  4*DIGITS  packed result, most significant digit in the top nibble; held between conversions

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; busy=0; done=0; BCD=0; internal shift/count registers=0.
  - Reset overrides all other inputs.
  - Reset during SHIFT aborts the conversion: no done pulse is produced and BCD reads 0.
- States:
  - IDLE:
    - start==1 at edge k: load shift register {DIGITS*4 zeros, data_in}, count=0, busy<=1, go to SHIFT.
    - start==0: remain in IDLE.
  - SHIFT: on each edge k+1..k+WIDTH perform one iteration:
    - For every BCD nibble >= 5, add 3 to that nibble (all nibbles in parallel, using pre-shift values).
    - Shift the whole register left by 1.
    - Increment count.
  - Completion, on the edge where the WIDTH-th iteration executes (edge k+WIDTH):
    - BCD <= final BCD field.
    - done <= 1, busy <= 0, state <= IDLE.
- Latency and handshake:
  - done is visible in the cycle following edge k+WIDTH, i.e. WIDTH clocks after the start-accept edge.
  - busy is high for exactly WIDTH cycles per conversion.
  - done is high for exactly 1 cycle and is low in all other cycles.
  - start while busy==1 is ignored: not queued, and data_in is not re-sampled.
  - start asserted in the cycle done==1 is accepted, since the state is already IDLE. This gives back-to-back conversions at one result per WIDTH+1 cycles, maximum throughput.
  - data_in changes after the accept edge have no effect on the in-flight conversion.
  - start held high continuously retriggers a conversion each time IDLE is re-entered.
- Output hold: BCD changes only at a completion edge or at reset. It must not show intermediate shift values at any time.
- Arithmetic:
  - Nibble adjust is a 4-bit add with no carry into the neighbouring nibble; the value is guaranteed <= 12 before the shift.
  - Input is unsigned; the full WIDTH range 0..2^WIDTH-1 is supported.
  - count width is clog2(WIDTH+1).

Test Plan:
- Reset low 2 cycles, then high; start=1 with data_in=8'd255 for 1 cycle -> busy=1 for 8 cycles; done pulses in cycle 8 after accept; BCD=12'h255; busy=0 in the same cycle.
- Convert 8'd0, 8'd9, 8'd10, 8'd99, 8'd100 sequentially -> BCD=12'h000, 12'h009, 12'h010, 12'h099, 12'h100, each with exactly one done pulse. Additionally sweep all 256 values against a reference model.
- Accept 8'd200, then pulse start with data_in=8'd17 at cycle 3 of busy -> ignored; result BCD=12'h200; only one done pulse; no second conversion starts.
- Accept 8'd123; change data_in to 8'd45 on the following cycle -> BCD=12'h123.
- Accept 8'd250; assert start with data_in=8'd7 in the done cycle -> BCD=12'h250 in that cycle, then 12'h007 with done exactly 8 cycles after that accept edge.
- After a prior result of 12'h042, accept 8'd199 and drive reset=0 at cycle 4 of busy -> busy=0, done never pulses, BCD=12'h000. After reset is released, converting 8'd199 gives 12'h199.
